utop: RTL
=========

// Module: utop
// PURPOSE
//  Unpacker feeding the Keccak permutation core. Collects a 1600-bit SHA3 state
//  streamed as 8 beats of 200 bits, each beat carrying a 3-bit tag.
//  Rebuilds the state as din[x][y][z] lanes plus a 24-bit packed tag vector.
//  Issues a single push to the permutation engine; inverse of its 200-bit output serializer.
// PARAMETERS
//  none (widths fixed by keccak_pkg constants: LANE_W=64, BEAT_W=200, NBEATS=8, IX_W=3)
// PORTS
//  clk       input   1               clock, all state on rising edge
//  reset_n   input   1               asynchronous, active-low reset
//  pushin    input   1               beat valid
//  firstin   input   1               qualifies beat 0 of a state (valid only with pushin)
//  din       input   200             beat data
//  dinix     input   3               per-beat tag
//  pushout   output  1               one-cycle pulse: dout/dix hold a complete state
//  dix       output  24              packed tags, beat k tag at dix[3k+2:3k]
//  dout      output  [4:0][4:0][63:0] state, lane (x,y) bit z
//  err       output  1               sticky framing error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0, async): pushout=0, dout=0, dix=0, err=0, beat count cnt=0, state IDLE.
//    Reset mid-frame discards the partial frame; no pushout.
//  - FSM IDLE/COLLECT, 3-bit beat counter cnt, 1600-bit assembly buffer abuf, 24-bit tag buffer tbuf.
//  - Accepted beat: abuf <= {din, abuf[1599:200]}; tbuf <= {dinix, tbuf[23:3]}.
//    After 8 beats, beat k sits at abuf[200k+199:200k].
//  - IDLE:
//    - pushin&firstin: accept beat, cnt=1, go to COLLECT.
//    - pushin&!firstin: beat dropped, error event.
//  - COLLECT:
//    - pushin&!firstin: accept beat, cnt++.
//    - pushin&firstin: partial frame discarded, error event. Treat as beat 0: cnt=1, stay in COLLECT.
//    - pushin=0: hold; gaps of any length are allowed between beats.
//  - Completion: the edge accepting beat 7 (cnt==7) also loads the output registers and sets pushout=1.
//    - dout[x][y][z] = {din,abuf[1599:200]}[64*(5y+x)+z].
//    - dix = {dinix,tbuf[23:3]}.
//    - Go to IDLE, cnt=0.
//    - pushout is a 1-cycle pulse, registered, visible the cycle after beat 7.
//  - dout/dix hold until the next completion. They are separate from abuf, so back-to-back frames
//    with zero idle cycles are supported: beat 0 of the next frame may arrive the cycle pushout=1.
//  - No backpressure: downstream always accepts the pushout cycle.
//  - firstin while pushin=0 is ignored.
//  - Counter never wraps silently: cnt==7 acceptance always completes.
// CONFIGURATION
//  - UTOP_ERR_EN defined: err sets on any error event, sticky until reset_n.
//  - UTOP_ERR_EN undefined: err tied 0, no error logic; framing recovery (drop/restart) is unchanged.
// STRUCTURE
//  - keccak_pkg:
//    - constants LANE_W, BEAT_W, NBEATS, IX_W
//    - typedef state_t = logic [4:0][4:0][63:0]
//    - typedef utop_st_e {IDLE, COLLECT}
//  - Sub-module keccak_lane_map (combinational flat 1600-bit -> state_t); shared with other stages needing the same map.
// TESTING
//  - Reset: hold reset_n=0 with pushin=1 -> pushout=0, dout=0, dix=0, err=0 throughout.
//  - Single frame: beats k=0..7, din={25{8'(k+1)}}, dinix=k, firstin on k=0.
//    -> pushout 1 cycle after beat 7, single cycle; dix=24'hFAC688; dout[0][0]=64'h0101..01; dout[4][4]=64'h0808..08.
//  - Lane map: beat0 din=200'h1, beat7 din=1<<199, others 0.
//    -> only dout[0][0][0] and dout[4][4][63] are 1.
//  - Gaps: pushin low 3 cycles between beats 3 and 4 -> same dout/dix as single frame; pushout 1 cycle after beat 7.
//  - Back-to-back: two frames, zero gap, second uses din={25{8'hA5}} -> two pulses 8 cycles apart.
//    dout after the second = all-A5; first dout held stable for 8 cycles.
//  - Errors:
//    - firstin on beat 5 -> partial frame dropped, err=1 (UTOP_ERR_EN). The following 8 beats produce a correct pushout.
//    - Stray pushin&!firstin in IDLE -> dropped, err=1.
//    - reset_n pulse at beat 4 -> no pushout, err=0.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths and types for the Keccak state path.
//   LANE_W/BEAT_W/NBEATS/IX_W are the fixed stream geometry; state_t is the
//   5x5 lane array indexed [x][y][z]; utop_st_e is the unpacker FSM state.
package keccak_pkg;

  localparam int unsigned LANE_W  = 64;
  localparam int unsigned BEAT_W  = 200;
  localparam int unsigned NBEATS  = 8;
  localparam int unsigned IX_W    = 3;
  localparam int unsigned STATE_W = LANE_W * 25;
  localparam int unsigned TAG_W   = IX_W * NBEATS;
  localparam int unsigned CNT_W   = 3;

  typedef logic [4:0][4:0][LANE_W-1:0] state_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } utop_st_e;

endpackage

// File: rtl/keccak_lane_map.sv
// keccak_lane_map: flat 1600-bit state -> lane array.
//   flat_i   in  [1599:0]  flat state, lane (x,y) at bits 64*(5y+x) +: 64
//   state_o  out state_t   state_o[x][y][z]
// Purely combinational wiring.
module keccak_lane_map
  import keccak_pkg::*;
(
  input  logic [STATE_W-1:0] flat_i,
  output state_t             state_o
);

  for (genvar x = 0; x < 5; x++) begin : g_x
    for (genvar y = 0; y < 5; y++) begin : g_y
      assign state_o[x][y] = flat_i[LANE_W*(5*y+x) +: LANE_W];
    end
  end

endmodule

// File: rtl/utop.sv
// utop: beat unpacker in front of the Keccak permutation core.
//   Collects 8 beats of 200 bits (+3-bit tag each) into one 1600-bit state and
//   pulses pushout for one cycle with the rebuilt lanes and packed tags.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   pushin, firstin    beat valid, beat-0 marker
//   din[199:0]         beat data
//   dinix[2:0]         beat tag
//   pushout            1-cycle pulse, dout/dix hold a complete state
//   dix[23:0]          tags, beat k at dix[3k+2:3k]
//   dout               lanes [x][y][z]
//   err                sticky framing error
// Build option: define UTOP_ERR_EN to enable the sticky err flag; otherwise
// err is constant 0 and only the drop/restart recovery remains.
module utop
  import keccak_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pushin,
  input  logic                   firstin,
  input  logic [BEAT_W-1:0]      din,
  input  logic [IX_W-1:0]        dinix,
  output logic                   pushout,
  output logic [TAG_W-1:0]       dix,
  output logic [4:0][4:0][63:0]  dout,
  output logic                   err
);

  // Only beats 0..6 need storage: beat 7 is taken straight from din on the
  // completing edge.
  localparam int unsigned ABUF_W = BEAT_W * (NBEATS - 1);
  localparam int unsigned TBUF_W = IX_W * (NBEATS - 1);

  utop_st_e            st_q, st_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ABUF_W-1:0]   abuf_q, abuf_d;
  logic [TBUF_W-1:0]   tbuf_q, tbuf_d;
  logic                pushout_q;
  logic [TAG_W-1:0]    dix_q;
  state_t              dout_q;

  logic [STATE_W-1:0]  frame_c;
  logic [TAG_W-1:0]    tags_c;
  state_t              map_c;
  logic                load_c;

  // Incoming beat shifted in on top of the stored beats.
  assign frame_c = {din, abuf_q};
  assign tags_c  = {dinix, tbuf_q};

  keccak_lane_map u_lane_map (
    .flat_i  (frame_c),
    .state_o (map_c)
  );

`ifdef UTOP_ERR_EN
  logic err_ev_c;
  logic err_q;
`endif

  // Next-state: framing FSM, beat counter, assembly buffers.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    abuf_d = abuf_q;
    tbuf_d = tbuf_q;
    load_c = 1'b0;
`ifdef UTOP_ERR_EN
    err_ev_c = 1'b0;
`endif
    case (st_q)
      IDLE: begin
        if (pushin) begin
          if (firstin) begin
            abuf_d = frame_c[STATE_W-1:BEAT_W];
            tbuf_d = tags_c[TAG_W-1:IX_W];
            cnt_d  = CNT_W'(1);
            st_d   = COLLECT;
          end else begin
`ifdef UTOP_ERR_EN
            err_ev_c = 1'b1;
`endif
          end
        end
      end
      COLLECT: begin
        if (pushin) begin
          abuf_d = frame_c[STATE_W-1:BEAT_W];
          tbuf_d = tags_c[TAG_W-1:IX_W];
          if (firstin) begin
            // Restart: this beat becomes beat 0 of a new frame.
            cnt_d = CNT_W'(1);
`ifdef UTOP_ERR_EN
            err_ev_c = 1'b1;
`endif
          end else if (cnt_q == CNT_W'(NBEATS - 1)) begin
            load_c = 1'b1;
            cnt_d  = '0;
            st_d   = IDLE;
          end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      abuf_q    <= '0;
      tbuf_q    <= '0;
      pushout_q <= 1'b0;
      dix_q     <= '0;
      dout_q    <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      abuf_q    <= abuf_d;
      tbuf_q    <= tbuf_d;
      pushout_q <= load_c;
      if (load_c) begin
        dix_q  <= tags_c;
        dout_q <= map_c;
      end
    end
  end

`ifdef UTOP_ERR_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (err_ev_c) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign pushout = pushout_q;
  assign dix     = dix_q;
  assign dout    = dout_q;

endmodule
